// File: rtl/nack_crc_checker.sv
// nack_crc_checker: per-packet CRC/format checker with an external combinational CRC engine.
// Optional error counter port err_cnt is enabled by defining NACK_CRC_ERR_CNT_EN.
`default_nettype none

module nack_crc_checker #(
    parameter logic [31:0] SEED  = 32'hFFFF_FFFF,
    parameter int          LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [511:0]     s_data,
    input  logic [63:0]      s_keep,
    input  logic             s_last,
    input  logic [31:0]      s_fcs,
    input  logic [31:0]      s_seq,
    output logic [511:0]     crc_din,
    output logic [31:0]      crc_cyc,
    input  logic [31:0]      crc_dout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic             res_fmt_err,
    output logic [31:0]      res_seq,
    output logic [LEN_W-1:0] res_len
`ifdef NACK_CRC_ERR_CNT_EN
    ,
    output logic [31:0]      err_cnt
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      crc_run_q, crc_run_d;
    logic             fmt_q, fmt_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      seq_q, seq_d;
    logic             res_valid_q, res_valid_d;
    logic             res_ok_q, res_ok_d;
    logic             res_fmt_q, res_fmt_d;
    logic [31:0]      res_seq_q, res_seq_d;
    logic [LEN_W-1:0] res_len_q, res_len_d;

    logic             in_idle;
    logic             accept;
    logic             keep_bad;
    logic             fmt_cur;
    logic             ok_cur;
    logic [LEN_W-1:0] cnt_base;
    logic [LEN_W-1:0] cnt_cur;
    logic [31:0]      seq_cur;

    // Disabled bytes are zeroed so the engine sees a deterministic tail.
    for (genvar b = 0; b < 64; b++) begin : g_byte
        assign crc_din[b*8 +: 8] = s_data[b*8 +: 8] & {8{s_keep[b]}};
    end

    assign in_idle = (state_q == ST_IDLE);
    assign crc_cyc = in_idle ? SEED : crc_run_q;
    assign s_ready = !res_valid_q || res_ready;
    assign accept  = s_valid && s_ready;

    // A contiguous mask is 2^n-1 with n>0: adding one clears every set bit.
    assign keep_bad = (s_keep == 64'd0) || ((s_keep & (s_keep + 64'd1)) != 64'd0);
    assign fmt_cur  = (!in_idle && fmt_q) || keep_bad;
    assign cnt_base = in_idle ? '0 : cnt_q;
    assign cnt_cur  = (cnt_base == '1) ? cnt_base : cnt_base + LEN_W'(1);
    assign seq_cur  = in_idle ? s_seq : seq_q;
    assign ok_cur   = ((~crc_dout) == s_fcs) && !fmt_cur;

    always_comb begin
        state_d     = state_q;
        crc_run_d   = crc_run_q;
        fmt_d       = fmt_q;
        cnt_d       = cnt_q;
        seq_d       = seq_q;
        res_valid_d = res_valid_q;
        res_ok_d    = res_ok_q;
        res_fmt_d   = res_fmt_q;
        res_seq_d   = res_seq_q;
        res_len_d   = res_len_q;

        if (res_ready) begin
            res_valid_d = 1'b0;
        end

        if (accept) begin
            if (s_last) begin
                state_d     = ST_IDLE;
                crc_run_d   = SEED;
                fmt_d       = 1'b0;
                cnt_d       = '0;
                res_valid_d = 1'b1;
                res_ok_d    = ok_cur;
                res_fmt_d   = fmt_cur;
                res_seq_d   = seq_cur;
                res_len_d   = cnt_cur;
            end else begin
                state_d   = ST_BODY;
                crc_run_d = crc_dout;
                fmt_d     = fmt_cur;
                cnt_d     = cnt_cur;
                seq_d     = seq_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            crc_run_q   <= SEED;
            fmt_q       <= 1'b0;
            cnt_q       <= '0;
            seq_q       <= 32'd0;
            res_valid_q <= 1'b0;
            res_ok_q    <= 1'b0;
            res_fmt_q   <= 1'b0;
            res_seq_q   <= 32'd0;
            res_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            crc_run_q   <= crc_run_d;
            fmt_q       <= fmt_d;
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            res_valid_q <= res_valid_d;
            res_ok_q    <= res_ok_d;
            res_fmt_q   <= res_fmt_d;
            res_seq_q   <= res_seq_d;
            res_len_q   <= res_len_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_ok      = res_ok_q;
    assign res_fmt_err = res_fmt_q;
    assign res_seq     = res_seq_q;
    assign res_len     = res_len_q;

`ifdef NACK_CRC_ERR_CNT_EN
    logic [31:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 32'd0;
        end else if (accept && s_last && !ok_cur && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_q <= err_cnt_q + 32'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nack_crc_checker.sv
// tb_nack_crc_checker: randomized packets checked cycle by cycle against a packet-level model.
`default_nettype none

module tb_nack_crc_checker;

    localparam logic [31:0] SEED  = 32'hFFFF_FFFF;
    localparam int          LEN_W = 4;
    localparam int          MAXL  = (1 << LEN_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [511:0]     s_data;
    logic [63:0]      s_keep;
    logic             s_last;
    logic [31:0]      s_fcs;
    logic [31:0]      s_seq;
    logic [511:0]     crc_din;
    logic [31:0]      crc_cyc;
    logic [31:0]      crc_dout;
    logic             res_valid;
    logic             res_ready;
    logic             res_ok;
    logic             res_fmt_err;
    logic [31:0]      res_seq;
    logic [LEN_W-1:0] res_len;
`ifdef NACK_CRC_ERR_CNT_EN
    logic [31:0]      err_cnt;
`endif

    nack_crc_checker #(.SEED(SEED), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
        .s_last(s_last), .s_fcs(s_fcs), .s_seq(s_seq),
        .crc_din(crc_din), .crc_cyc(crc_cyc), .crc_dout(crc_dout),
        .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok),
        .res_fmt_err(res_fmt_err), .res_seq(res_seq), .res_len(res_len)
`ifdef NACK_CRC_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in CRC engine: any deterministic mix of running value and data works.
    function automatic logic [31:0] eng(input logic [31:0] c, input logic [511:0] d);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 16; i++) begin
            x = {x[26:0], x[31:27]} ^ d[i*32 +: 32];
            x = x + 32'h9E37_79B9;
        end
        return x;
    endfunction

    assign crc_dout = eng(crc_cyc, crc_din);

    function automatic logic [511:0] mask(input logic [511:0] d, input logic [63:0] k);
        logic [511:0] m;
        m = '0;
        for (int b = 0; b < 64; b++) if (k[b]) m[b*8 +: 8] = d[b*8 +: 8];
        return m;
    endfunction

    function automatic bit noncontig(input logic [63:0] k);
        int hi;
        hi = -1;
        for (int i = 0; i < 64; i++) if (k[i]) hi = i;
        if (hi < 0) return 1'b1;
        for (int i = 0; i < hi; i++) if (!k[i]) return 1'b1;
        return 1'b0;
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_in_pkt;
    logic [31:0] m_run;
    bit          m_fmt;
    int          m_cnt;
    logic [31:0] m_sq;
    bit          m_rv, m_ok, m_fe;
    logic [31:0] m_seq;
    int          m_len;
    logic [31:0] m_err;
    int          stall_left;

    task automatic model_reset();
        m_in_pkt = 0; m_run = SEED; m_fmt = 0; m_cnt = 0; m_sq = 0;
        m_rv = 0; m_ok = 0; m_fe = 0; m_seq = 0; m_len = 0; m_err = 0;
        stall_left = 0;
    endtask

    task automatic step(input bit v, input logic [511:0] d, input logic [63:0] k, input bit last,
                        input logic [31:0] fcs, input logic [31:0] sq, output bit acc);
        logic [511:0] md;
        logic [31:0]  cyc, c, sqv;
        bit           f, exp_rdy;
        int           n;
        @(negedge clk);
        if (stall_left > 0) begin
            res_ready = 1'b0;
            stall_left--;
        end else begin
            res_ready = 1'b1;
        end
        s_valid = v; s_data = d; s_keep = k; s_last = last; s_fcs = fcs; s_seq = sq;
        #1;
        exp_rdy = !m_rv || res_ready;
        check_eq("s_ready", s_ready, exp_rdy);
        check_eq("res_valid", res_valid, m_rv);
        if (m_rv) begin
            check_eq("res_ok", res_ok, m_ok);
            check_eq("res_fmt_err", res_fmt_err, m_fe);
            check_eq("res_seq", res_seq, m_seq);
            check_eq("res_len", res_len, m_len);
        end
`ifdef NACK_CRC_ERR_CNT_EN
        check_eq("err_cnt", err_cnt, m_err);
`endif
        md  = mask(d, k);
        cyc = m_in_pkt ? m_run : SEED;
        if (v) begin
            check_eq("crc_cyc", crc_cyc, cyc);
            check_eq("crc_din", crc_din, md);
        end
        acc = v && exp_rdy;
        if (acc && last) begin
            c   = eng(cyc, md);
            f   = (m_in_pkt && m_fmt) || noncontig(k);
            n   = (m_in_pkt ? m_cnt : 0) + 1;
            sqv = m_in_pkt ? m_sq : sq;
            m_rv = 1; m_ok = ((~c) == fcs) && !f; m_fe = f; m_seq = sqv;
            m_len = (n > MAXL) ? MAXL : n;
            if (!m_ok && m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
            m_in_pkt = 0;
        end else begin
            if (res_ready) m_rv = 0;
            if (acc) begin
                c   = eng(cyc, md);
                f   = (m_in_pkt && m_fmt) || noncontig(k);
                n   = (m_in_pkt ? m_cnt : 0) + 1;
                sqv = m_in_pkt ? m_sq : sq;
                m_in_pkt = 1; m_run = c; m_fmt = f; m_cnt = n; m_sq = sqv;
            end
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, a);
    endtask

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input bit last,
                             input bit bad, input logic [31:0] sq);
        bit          a;
        int          tries;
        logic [31:0] fcs;
        a = 0; tries = 0;
        while (!a) begin
            // Good FCS is the complement of the engine result over the whole packet.
            fcs = ~eng(m_in_pkt ? m_run : SEED, mask(d, k));
            if (bad) fcs[0] = ~fcs[0];
            step(1'b1, d, k, last, fcs, sq, a);
            tries++;
            if (!a && tries > 64) begin
                check_eq("accept_timeout", 1'b0, 1'b1);
                return;
            end
        end
    endtask

    function automatic logic [511:0] rnd_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [63:0] rnd_keep();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return '1;
        if (r <= 7) return (64'd1 << $urandom_range(1, 63)) - 64'd1;
        if (r == 8) return '0;
        return {$urandom, $urandom};
    endfunction

    // Middle beats use full masks unless rk is set; the first and last beats take kf/kl.
    task automatic send_pkt(input int n, input bit bad, input logic [31:0] sq,
                            input logic [63:0] kf, input logic [63:0] kl, input bit rk);
        logic [63:0] k;
        for (int i = 0; i < n; i++) begin
            if (rk) k = rnd_keep();
            else if (i == n - 1) k = kl;
            else if (i == 0) k = kf;
            else k = '1;
            send_beat(rnd_data(), k, (i == n - 1), bad, (i == 0) ? sq : $urandom);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        model_reset();
        check_eq("rst_res_valid", res_valid, 1'b0);
        check_eq("rst_res_ok", res_ok, 1'b0);
        check_eq("rst_res_fmt", res_fmt_err, 1'b0);
        check_eq("rst_res_seq", res_seq, 32'd0);
        check_eq("rst_res_len", res_len, '0);
        check_eq("rst_crc_cyc", crc_cyc, SEED);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 0; s_data = '0; s_keep = '0; s_last = 0;
        s_fcs = '0; s_seq = '0; res_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        pulse_reset();

        // single-beat good packet, seq 5
        send_pkt(1, 1'b0, 32'd5, '1, '1, 1'b0);
        idle(1);
        // three beats, partial last beat
        send_pkt(3, 1'b0, 32'd7, '1, 64'h0000_0000_0000_00FF, 1'b0);
        idle(1);
        // FCS off by one bit
        send_pkt(2, 1'b1, 32'd9, '1, '1, 1'b0);
        idle(1);
        // non-contiguous first beat, matching FCS
        send_pkt(2, 1'b0, 32'd11, 64'h0F0F, '1, 1'b0);
        // all-zero keep on a single beat
        send_pkt(1, 1'b0, 32'd12, '1, 64'd0, 1'b0);
        idle(1);
        // back-pressure: result held while the next packet waits
        send_pkt(1, 1'b0, 32'd20, '1, '1, 1'b0);
        stall_left = 4;
        send_pkt(2, 1'b0, 32'd21, '1, '1, 1'b0);
        idle(2);
        // reset mid-packet, then a fresh packet from SEED
        send_pkt(2, 1'b0, 32'd30, '1, '1, 1'b0);
        m_in_pkt = m_in_pkt;
        send_beat(rnd_data(), '1, 1'b0, 1'b0, $urandom);
        pulse_reset();
        idle(2);
        send_pkt(1, 1'b0, 32'd31, '1, '1, 1'b0);
        idle(1);
        // beat counter saturation
        send_pkt(MAXL + 3, 1'b0, 32'd40, '1, '1, 1'b0);
        send_pkt(MAXL, 1'b0, 32'd41, '1, '1, 1'b0);
        idle(1);

        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 3) == 0) stall_left = $urandom_range(1, 3);
            send_pkt($urandom_range(1, 5), ($urandom_range(0, 2) == 0), $urandom, '1, '1,
                     ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nack_crc_checker.md
NACK_CRC_CHECKER -- requirements
Module: nack_crc_checker

Interface
REQ-001 SHALL have parameter SEED, default 32'hFFFF_FFFF, initial CRC value loaded on the first beat of each packet.
REQ-002 SHALL have parameter LEN_W, default 16, width of the per-packet beat counter.
REQ-003 SHALL use one clock and an asynchronous active-low reset. Ports are:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
REQ-004 SHALL have these packet-input ports:
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid&&s_ready
- s_data  in  512  beat data; byte 0 = s_data[7:0]
- s_keep  in  64  byte enables; contiguous from bit 0
- s_last  in  1  final beat of packet
- s_fcs  in  32  expected CRC, sampled on the last beat only
- s_seq  in  32  packet sequence number, sampled on the first beat
REQ-005 SHALL have these ports to the CRC engine:
- crc_din  out  512  s_data with each byte whose s_keep bit is 0 forced to 8'h00
- crc_cyc  out  32  running CRC input: SEED on the first beat, else the running register
- crc_dout  in  32  engine result; combinational, same cycle
REQ-006 SHALL have these result ports:
- res_valid  out  1  result pending
- res_ready  in  1  result consumed when res_valid&&res_ready
- res_ok  out  1  CRC matched and format good
- res_fmt_err  out  1  non-contiguous s_keep seen in the packet
- res_seq  out  32  sequence number of the checked packet
- res_len  out  LEN_W  beats in the packet, saturating

Function
REQ-007 SHALL run a two-state FSM. IDLE means no beat of a packet has been accepted yet. BODY means mid-packet.
REQ-008 In IDLE, an accepted beat with s_last=0 SHALL move the FSM to BODY. An accepted beat with s_last=1 SHALL keep it in IDLE, as a single-beat packet.
REQ-009 In BODY, an accepted beat with s_last=1 SHALL return the FSM to IDLE. No other event leaves BODY.
REQ-010 SHALL drive crc_din and crc_cyc combinationally from the current s_data/s_keep and FSM state. crc_cyc is SEED in IDLE and crc_run in BODY.
REQ-011 On every accepted non-last beat, crc_run SHALL be loaded with crc_dout.
REQ-012 On an accepted last beat, the result register SHALL be loaded on the next clock edge, so res_valid rises 1 cycle after acceptance. It holds:
- res_ok = (~crc_dout == s_fcs) && !fmt_flag
- res_fmt_err = fmt_flag
- res_seq = the captured sequence number
- res_len = beat count including the last beat
REQ-013 s_keep SHALL be non-contiguous when it is nonzero and has a 0 bit below its highest 1 bit, or when it is all zero. A non-contiguous s_keep on any beat SHALL set fmt_flag for the rest of that packet. fmt_flag clears when the packet ends.
REQ-014 The beat counter SHALL saturate at 2^LEN_W-1 and SHALL never wrap.
REQ-015 s_ready SHALL equal !res_valid || res_ready. A result and the next packet's last beat may complete in the same cycle with no bubble.
REQ-016 res_valid SHALL stay high, with all res_* outputs stable, until res_ready is sampled high.
REQ-017 s_seq SHALL be captured only on the first beat of a packet. Changes to s_seq on later beats SHALL be ignored.

Reset
REQ-018 rst_n low SHALL asynchronously force the following, including mid-packet, where the partial packet is discarded with no result:
- FSM to IDLE
- crc_run = SEED
- fmt_flag = 0
- beat counter = 0
- res_valid = 0, res_ok = 0, res_fmt_err = 0
- res_seq = 0, res_len = 0
REQ-019 Reset SHALL be released synchronously to clk by the surrounding logic. s_ready is 1 in the first cycle after reset.

Configuration
REQ-020 With the macro NACK_CRC_ERR_CNT_EN defined, the block SHALL add output err_cnt (out, 32). err_cnt resets to 0 and increments by 1 on each result load with res_ok=0. It saturates at 32'hFFFF_FFFF.
REQ-021 Without NACK_CRC_ERR_CNT_EN, port err_cnt and its counter SHALL be absent. All other behaviour is identical.

Verification
REQ-022 Single beat, s_keep all-ones, s_fcs = ~crc_dout, s_seq=5 -> res_valid 1 cycle later, res_ok=1, res_seq=5, res_len=1.
REQ-023 Three-beat packet with correct FCS, last s_keep=64'h0000_0000_0000_00FF -> crc_cyc = SEED, dout1, dout2 on successive beats; upper 56 bytes of crc_din are zero on the last beat; res_ok=1, res_len=3.
REQ-024 Two-beat packet with s_fcs off by one bit -> res_ok=0, res_fmt_err=0. With NACK_CRC_ERR_CNT_EN defined, err_cnt goes 0->1.
REQ-025 s_keep=64'h0F0F on the first beat of a two-beat packet -> res_fmt_err=1, res_ok=0 even when the FCS matches.
REQ-026 res_ready held 0 for 4 cycles while a second packet is offered -> s_ready=0 and the result stays stable. res_ready=1 -> s_ready=1 in the same cycle, and the second result follows.
REQ-027 rst_n pulsed low after beat 2 of a 4-beat packet -> no res_valid, FSM in IDLE. The next single-beat packet uses crc_cyc=SEED and passes.
